dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, 16, bus cycles waited for bus_ack before an access is aborted (range 2..255).
REQ-002 Parameter ERR_RDATA, 32'h0000_0000, ReadData value returned on an aborted or misaligned read.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 MemRead  input  1  datapath requests a word load this instruction.
REQ-006 MemWrite  input  1  datapath requests a word store this instruction.
REQ-007 ALUResult  input  32  byte address from the datapath ALU.
REQ-008 WriteData  input  32  store data from the register file.
REQ-009 ReadData  output  32  registered load data to the datapath result mux.
REQ-010 Stall  output  1  freezes PC and register writeback while high.
REQ-011 MemErr  output  1  sticky error flag (timeout or misalignment).
REQ-012 err_clr  input  1  synchronous clear of MemErr.
REQ-013 bus_req, bus_we  output  1 each  request valid, write enable.
REQ-014 bus_addr  output  32  word-aligned address (bits [1:0] = 0).
REQ-015 bus_wdata  output  32  store data.
REQ-016 bus_rdata  input  32  load data, valid in the bus_ack cycle.
REQ-017 bus_ack  input  1  one-cycle completion strobe from memory.

Function
REQ-018 States SHALL be IDLE, REQ, DONE.
REQ-019 IDLE: on MemRead|MemWrite, latch address, WriteData, and we=MemWrite; go to REQ; if MemRead and MemWrite are both high, the access SHALL be a write.
REQ-020 IDLE with ALUResult[1:0] != 0 and an access request: no bus cycle; set MemErr; load ERR_RDATA into ReadData on a read; go to DONE.
REQ-021 Stall = (state==REQ) | (state==IDLE & (MemRead|MemWrite)); combinational, so the datapath holds in the request cycle.
REQ-022 REQ: bus_req=1, bus_addr/bus_we/bus_wdata SHALL stay constant until exit.
REQ-023 REQ with bus_ack: on a read, ReadData <= bus_rdata; go to DONE next edge.
REQ-024 Timeout counter SHALL clear on REQ entry and increment each REQ cycle without ack; when count reaches TIMEOUT-1 without ack, set MemErr, ReadData <= ERR_RDATA on a read, and go to DONE.
REQ-025 bus_ack and timeout in the same cycle: ack SHALL win and no error is raised.
REQ-026 DONE: Stall=0, bus_req=0 for exactly one cycle, then IDLE unconditionally; no new access is launched from DONE.
REQ-027 bus_ack outside REQ SHALL be ignored.
REQ-028 ReadData SHALL hold its value until the next completed read; writes SHALL NOT alter it.
REQ-029 MemErr: set has priority over err_clr in the same cycle.
REQ-030 Latency: successful access = 1 request cycle + N wait cycles + 1 DONE cycle; zero-wait access stalls exactly 1 cycle.

Reset
REQ-031 Reset assertion SHALL immediately force state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, ReadData=0, MemErr=0, and timeout counter=0.
REQ-032 Stall SHALL be 0 while reset is high.
REQ-033 Reset mid-REQ SHALL abandon the access; a late bus_ack SHALL be ignored.

Structure
REQ-034 A shared package SHALL hold the state enumeration, the default TIMEOUT and ERR_RDATA constants, and the 32-bit word width.
REQ-035 The timeout counter SHALL be a sub-module named bus_timer, with clear, enable, and expired ports.

Verification
REQ-036 Read at 0x100, ack on the first REQ cycle, bus_rdata=0xCAFEF00D: Stall high 1 cycle, then ReadData=0xCAFEF00D in DONE, MemErr=0.
REQ-037 Write at 0x204 of 0x12345678, ack after 3 wait cycles: bus_addr=0x204, bus_we=1, wdata stable 4 REQ cycles, Stall high 4 cycles, then DONE.
REQ-038 Read at 0x40, no ack, TIMEOUT=16: exit REQ after 16 cycles, MemErr=1, ReadData=0x0; err_clr pulse then returns MemErr=0.
REQ-039 Read at 0x102 (misaligned): bus_req never asserts, MemErr=1, DONE next cycle.
REQ-040 Reset asserted in the 2nd REQ cycle, ack one cycle later: bus_req drops asynchronously, state IDLE, ReadData=0, ack ignored.
REQ-041 MemRead=MemWrite=1 at 0x8 and ack coincident with the timeout cycle: write performed, MemErr stays 0.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and defaults for the data-memory controller.
package dmem_ctrl_pkg;

    localparam int WORD_W = 32;
    localparam int DEF_TIMEOUT = 16;
    localparam logic [WORD_W-1:0] DEF_ERR_RDATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_ctrl_bus_timer.sv
// Purpose: counts bus wait cycles and flags when the access must be abandoned.
// Latency: expired_o is combinational from the count; count updates each edge.
// Backpressure: none; enable_i simply freezes the count.
module bus_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/dmem_ctrl.sv
// Purpose: bridges single-cycle datapath loads/stores onto a req/ack memory bus.
// Latency: 1 request cycle + bus wait cycles + 1 DONE cycle; misaligned goes straight to DONE.
// Backpressure: Stall holds the datapath while a request is pending or in flight.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int                TIMEOUT   = DEF_TIMEOUT,
    parameter logic [WORD_W-1:0] ERR_RDATA = DEF_ERR_RDATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] ALUResult,
    input  logic [WORD_W-1:0] WriteData,
    output logic [WORD_W-1:0] ReadData,
    output logic              Stall,
    output logic              MemErr,
    input  logic              err_clr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [WORD_W-1:0] bus_addr,
    output logic [WORD_W-1:0] bus_wdata,
    input  logic [WORD_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] addr_q, wdata_q, rdata_q, rd_val;
    logic              we_q, err_q;
    logic              access, latch, rd_load, err_set, tmr_clr, tmr_en, expired;

    assign access = MemRead | MemWrite;

    bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (tmr_clr),
        .enable_i  (tmr_en),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        rd_load = 1'b0;
        rd_val  = rdata_q;
        err_set = 1'b0;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (ALUResult[1:0] != 2'b00) begin
                        err_set = 1'b1;
                        rd_load = ~MemWrite;
                        rd_val  = ERR_RDATA;
                        state_d = DONE;
                    end else begin
                        latch   = 1'b1;
                        tmr_clr = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                // Ack is checked first so a coincident timeout never raises an error.
                if (bus_ack) begin
                    rd_load = ~we_q;
                    rd_val  = bus_rdata;
                    state_d = DONE;
                end else if (expired) begin
                    err_set = 1'b1;
                    rd_load = ~we_q;
                    rd_val  = ERR_RDATA;
                    state_d = DONE;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                addr_q  <= {ALUResult[WORD_W-1:2], 2'b00};
                wdata_q <= WriteData;
                we_q    <= MemWrite;
            end
            if (rd_load) begin
                rdata_q <= rd_val;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign Stall     = ~reset & ((state_q == REQ) | ((state_q == IDLE) & access));
    assign bus_req   = (state_q == REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign ReadData  = rdata_q;
    assign MemErr    = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: vector table of whole transactions plus reset and error corner cases.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, err_clr, bus_ack;
    logic [31:0] ALUResult, WriteData, bus_rdata;
    logic [31:0] ReadData, bus_addr, bus_wdata;
    logic        Stall, MemErr, bus_req, bus_we;

    int checks   = 0;
    int failures = 0;

    dmem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .MemErr    (MemErr),
        .err_clr   (err_clr),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_at;     // REQ cycle index carrying ack, -1 for never
        int          exp_req;    // number of REQ cycles
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   n;
        logic stable;
        bit   done;
        MemRead   = v.rd;
        MemWrite  = v.wr;
        ALUResult = v.addr;
        WriteData = v.wdata;
        bus_ack   = 1'b0;
        #1;
        chk($sformatf("v%0d_launch_stall", idx), Stall, 1);
        @(posedge clk); #1;
        n = 0; stable = 1'b1; done = 1'b0;
        while (!done && n < 300) begin
            if (Stall) begin
                if (bus_req !== 1'b1 || bus_addr !== v.addr || bus_we !== v.wr || bus_wdata !== v.wdata)
                    stable = 1'b0;
                bus_ack   = (n == v.ack_at);
                bus_rdata = v.rdata;
                n++;
                @(posedge clk); #1;
                bus_ack = 1'b0;
            end else begin
                done = 1'b1;
            end
        end
        chk($sformatf("v%0d_exit_bound", idx), {31'd0, done}, 1);
        chk($sformatf("v%0d_req_cycles", idx), n, v.exp_req);
        if (v.exp_req > 0)
            chk($sformatf("v%0d_bus_stable", idx), stable, 1);
        // DONE cycle with the request still held: no stall, no relaunch
        chk($sformatf("v%0d_done_stall", idx), Stall, 0);
        chk($sformatf("v%0d_done_busreq", idx), bus_req, 0);
        chk($sformatf("v%0d_rdata", idx), ReadData, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), MemErr, v.exp_err);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        chk($sformatf("v%0d_idle_busreq", idx), bus_req, 0);
        if (v.exp_err) begin
            err_clr = 1'b1;
            @(posedge clk); #1;
            err_clr = 1'b0;
            chk($sformatf("v%0d_err_clr", idx), MemErr, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h1111_1111, 32'hCAFE_F00D,  0,  1, 32'hCAFE_F00D, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0204, 32'h1234_5678, 32'h9999_9999,  3,  4, 32'hCAFE_F00D, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h2222_2222, 32'h5555_5555, -1, 16, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0080, 32'h3333_3333, 32'hA5A5_5A5A,  1,  2, 32'hA5A5_5A5A, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0102, 32'h4444_4444, 32'h6666_6666,  0,  0, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h7777_7777, 32'h0BAD_CAFE, 14, 15, 32'h0BAD_CAFE, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 32'h8888_8888, 15, 16, 32'h0BAD_CAFE, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_0010, 32'hFEED_0010, 32'h1212_1212, -1, 16, 32'h0BAD_CAFE, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 32'h0000_0013, 32'hFEED_0013, 32'h3434_3434,  0,  0, 32'h0BAD_CAFE, 1'b1};

        reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; err_clr = 1'b0; bus_ack = 1'b0;
        ALUResult = 32'h100; WriteData = 32'h0; bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", Stall, 0);
        chk("rst_busreq", bus_req, 0);
        chk("rst_buswe", bus_we, 0);
        chk("rst_busaddr", bus_addr, 0);
        chk("rst_buswdata", bus_wdata, 0);
        chk("rst_rdata", ReadData, 0);
        chk("rst_err", MemErr, 0);
        MemRead = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // ack while idle must not touch ReadData
        bus_ack = 1'b1; bus_rdata = 32'h7777_0000;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("idle_ack_rdata", ReadData, 32'h0BAD_CAFE);
        chk("idle_ack_busreq", bus_req, 0);
        @(posedge clk); #1;
        chk("idle_ack_stall", Stall, 0);

        // reset in the 2nd REQ cycle, ack arriving one cycle later
        MemRead = 1'b1; ALUResult = 32'h300;
        @(posedge clk); #1;
        MemRead = 1'b0;
        chk("mid_rst_req1", bus_req, 1);
        @(posedge clk); #1;
        chk("mid_rst_req2", bus_req, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busreq_async", bus_req, 0);
        chk("mid_rst_stall", Stall, 0);
        chk("mid_rst_rdata", ReadData, 0);
        chk("mid_rst_busaddr", bus_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h0000_0077;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        chk("late_ack_rdata", ReadData, 0);
        chk("late_ack_busreq", bus_req, 0);
        chk("late_ack_stall", Stall, 0);
        chk("late_ack_err", MemErr, 0);

        // error set wins over a simultaneous clear
        MemRead = 1'b1; ALUResult = 32'h201; err_clr = 1'b1;
        @(posedge clk); #1;
        MemRead = 1'b0;
        chk("set_over_clr", MemErr, 1);
        @(posedge clk); #1;
        chk("clr_after_set", MemErr, 0);
        err_clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
